// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: sequencer control bundle (run/din/g_nz in, datapath enables out)
interface cpu_ctrl_if #(parameter int DATA_W = 16);
  logic              run;
  logic [DATA_W-1:0] din;
  logic              g_nz;
  logic [7:0]        rin;
  logic [7:0]        rout;
  logic              ain;
  logic              gin;
  logic              gout;
  logic              addsub;
  logic              dinout;
  logic              irin;
  logic              done;
  modport master (output run, din, g_nz,
                  input rin, rout, ain, gin, gout, addsub, dinout, irin, done);
  modport slave  (input run, din, g_nz,
                  output rin, rout, ain, gin, gout, addsub, dinout, irin, done);
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: T0-T3 instruction sequencer; define CPU_MVNZ_EN to add mvnz (opcode 100)
module cpu_ctrl_fsm #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input logic      clk,
  input logic      resetn,
  cpu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
  state_t          state_q, state_d;
  logic [8:0]      ir_q, ir_d;
  logic [2:0]      op, x, y;
  logic [NREG-1:0] x_oh, y_oh;
  logic            unused_in;
  assign {op, x, y} = ir_q;
  assign x_oh = NREG'(1) << x;
  assign y_oh = NREG'(1) << y;
`ifdef CPU_MVNZ_EN
  assign unused_in = ^bus.din[DATA_W-1:9];
`else
  assign unused_in = ^{bus.din[DATA_W-1:9], bus.g_nz};
`endif
  // state and instruction register; reset abandons any in-flight instruction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end
  // next-state and enable decode from (state, IR)
  always_comb begin
    state_d    = T0;
    ir_d       = ir_q;
    bus.rin    = '0;
    bus.rout   = '0;
    bus.ain    = 1'b0;
    bus.gin    = 1'b0;
    bus.gout   = 1'b0;
    bus.addsub = 1'b0;
    bus.dinout = 1'b0;
    bus.irin   = 1'b0;
    bus.done   = 1'b0;
    case (state_q)
      T0: begin
        bus.irin = bus.run & resetn;
        if (bus.run) begin
          ir_d    = bus.din[8:0];
          state_d = T1;
        end
      end
      T1: begin
        bus.done = 1'b1;
        case (op)
          3'b000: begin
            bus.rout = y_oh;
            bus.rin  = x_oh;
          end
          3'b001: begin
            bus.dinout = 1'b1;
            bus.rin    = x_oh;
          end
          3'b010, 3'b011: begin
            bus.done = 1'b0;
            bus.rout = x_oh;
            bus.ain  = 1'b1;
            state_d  = T2;
          end
`ifdef CPU_MVNZ_EN
          3'b100: begin
            bus.rout = bus.g_nz ? y_oh : '0;
            bus.rin  = bus.g_nz ? x_oh : '0;
          end
`endif
          default: ;
        endcase
      end
      T2: begin
        bus.rout   = y_oh;
        bus.gin    = 1'b1;
        bus.addsub = (op == 3'b011);
        state_d    = T3;
      end
      T3: begin
        bus.gout = 1'b1;
        bus.rin  = x_oh;
        bus.done = 1'b1;
      end
      default: state_d = T0;
    endcase
  end
endmodule
